// File: rtl/ssd1306_pkg.sv
// Shared types and opcodes for the SSD1306 command/data controller.
package ssd1306_pkg;

    typedef enum logic [1:0] {
        HORIZ = 2'd0,
        VERT  = 2'd1,
        PAGE  = 2'd2
    } addr_mode_t;

    typedef enum logic [1:0] {
        IDLE,
        ARG1,
        ARG2,
        SKIP
    } parser_state_t;

    // Prefixed so the names do not collide with the addressing-mode literals.
    typedef enum logic [1:0] {
        P_MODE,
        P_COL,
        P_PAGE
    } pend_t;

    localparam logic [7:0] CMD_SET_MODE    = 8'h20;
    localparam logic [7:0] CMD_COL_ADDR    = 8'h21;
    localparam logic [7:0] CMD_PAGE_ADDR   = 8'h22;
    localparam logic [7:0] CMD_SCROLL_R    = 8'h26;
    localparam logic [7:0] CMD_SCROLL_L    = 8'h27;
    localparam logic [7:0] CMD_VSCROLL_R   = 8'h29;
    localparam logic [7:0] CMD_VSCROLL_L   = 8'h2A;
    localparam logic [7:0] CMD_CONTRAST    = 8'h81;
    localparam logic [7:0] CMD_CHARGE_PUMP = 8'h8D;
    localparam logic [7:0] CMD_VSCROLL_AREA= 8'hA3;
    localparam logic [7:0] CMD_NORMAL      = 8'hA6;
    localparam logic [7:0] CMD_INVERT      = 8'hA7;
    localparam logic [7:0] CMD_MUX_RATIO   = 8'hA8;
    localparam logic [7:0] CMD_DISP_OFF    = 8'hAE;
    localparam logic [7:0] CMD_DISP_ON     = 8'hAF;
    localparam logic [7:0] CMD_DISP_OFFSET = 8'hD3;
    localparam logic [7:0] CMD_CLK_DIV     = 8'hD5;
    localparam logic [7:0] CMD_PRECHARGE   = 8'hD9;
    localparam logic [7:0] CMD_COM_PINS    = 8'hDA;
    localparam logic [7:0] CMD_VCOMH       = 8'hDB;

    function automatic logic is_one_arg(input logic [7:0] op);
        return (op == CMD_CONTRAST)   || (op == CMD_CHARGE_PUMP) ||
               (op == CMD_MUX_RATIO)  || (op == CMD_DISP_OFFSET) ||
               (op == CMD_CLK_DIV)    || (op == CMD_PRECHARGE)   ||
               (op == CMD_COM_PINS)   || (op == CMD_VCOMH);
    endfunction

endpackage

// File: rtl/ssd1306_cmd_ctrl_if.sv
// Byte-receive and framebuffer-write signals of the SSD1306 controller.
interface ssd1306_cmd_ctrl_if #(
    parameter int ADDR_W = 10
);
    logic              frame_abort;
    logic              rx_valid;
    logic              rx_dc;
    logic [7:0]        rx_data;
    logic              fb_we;
    logic [ADDR_W-1:0] fb_addr;
    logic [7:0]        fb_wdata;

    modport master (
        output frame_abort, rx_valid, rx_dc, rx_data,
        input  fb_we, fb_addr, fb_wdata
    );

    modport slave (
        input  frame_abort, rx_valid, rx_dc, rx_data,
        output fb_we, fb_addr, fb_wdata
    );
endinterface

// File: rtl/ssd1306_addr_gen.sv
// Combinational next-pointer logic for SSD1306 GDDRAM auto-increment.
module ssd1306_addr_gen
    import ssd1306_pkg::*;
#(
    parameter int COL_W  = 7,
    parameter int PAGE_W = 3
) (
    input  addr_mode_t        mode,
    input  logic [COL_W-1:0]  col,
    input  logic [PAGE_W-1:0] page,
    input  logic [COL_W-1:0]  col_start,
    input  logic [COL_W-1:0]  col_end,
    input  logic [PAGE_W-1:0] page_start,
    input  logic [PAGE_W-1:0] page_end,
    output logic [COL_W-1:0]  col_nxt,
    output logic [PAGE_W-1:0] page_nxt
);
    logic [COL_W-1:0]  col_inc;
    logic [PAGE_W-1:0] page_inc;

    // Power-of-two sizes: plain increment wraps at COLS-1 / PAGES-1.
    assign col_inc  = col + 1'b1;
    assign page_inc = page + 1'b1;

    always_comb begin
        col_nxt  = col;
        page_nxt = page;
        case (mode)
            HORIZ: begin
                if (col == col_end) begin
                    col_nxt  = col_start;
                    page_nxt = (page == page_end) ? page_start : page_inc;
                end else begin
                    col_nxt = col_inc;
                end
            end
            VERT: begin
                if (page == page_end) begin
                    page_nxt = page_start;
                    col_nxt  = (col == col_end) ? col_start : col_inc;
                end else begin
                    page_nxt = page_inc;
                end
            end
            default: col_nxt = col_inc;
        endcase
    end
endmodule

// File: rtl/ssd1306_cmd_ctrl.sv
// SSD1306 command parser and framebuffer writer.
// Optional START_LINE_EN: enables 0x40-0x7F display start line command.
module ssd1306_cmd_ctrl
    import ssd1306_pkg::*;
#(
    parameter int COLS   = 128,
    parameter int PAGES  = 8,
    parameter int ADDR_W = 10
) (
    input  logic                clk,
    input  logic                greset,
    ssd1306_cmd_ctrl_if.slave   bus,
    output logic                display_on,
    output logic                invert,
    output logic [5:0]          start_line
);
    localparam int COL_W  = $clog2(COLS);
    localparam int PAGE_W = $clog2(PAGES);

    parser_state_t     state_q, state_d;
    pend_t             pend_q, pend_d;
    logic [2:0]        skip_q, skip_d;
    addr_mode_t        mode_q, mode_d;
    logic [COL_W-1:0]  col_q, col_d, col_start_q, col_start_d, col_end_q, col_end_d;
    logic [PAGE_W-1:0] page_q, page_d, page_start_q, page_start_d, page_end_q, page_end_d;
    logic              disp_q, disp_d, inv_q, inv_d;
    logic              fb_we_q, fb_we_d;
    logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
    logic [7:0]        fb_wdata_q, fb_wdata_d;
    logic [COL_W-1:0]  col_nxt;
    logic [PAGE_W-1:0] page_nxt;
    logic [7:0]        col_ext;
    logic [7:0]        rx;
`ifdef START_LINE_EN
    logic [5:0]        start_line_q, start_line_d;
`endif

    assign rx = bus.rx_data;

    ssd1306_addr_gen #(.COL_W(COL_W), .PAGE_W(PAGE_W)) u_addr_gen (
        .mode       (mode_q),
        .col        (col_q),
        .page       (page_q),
        .col_start  (col_start_q),
        .col_end    (col_end_q),
        .page_start (page_start_q),
        .page_end   (page_end_q),
        .col_nxt    (col_nxt),
        .page_nxt   (page_nxt)
    );

    always_comb begin
        state_d      = state_q;
        pend_d       = pend_q;
        skip_d       = skip_q;
        mode_d       = mode_q;
        col_d        = col_q;
        page_d       = page_q;
        col_start_d  = col_start_q;
        col_end_d    = col_end_q;
        page_start_d = page_start_q;
        page_end_d   = page_end_q;
        disp_d       = disp_q;
        inv_d        = inv_q;
        fb_we_d      = 1'b0;
        fb_addr_d    = fb_addr_q;
        fb_wdata_d   = fb_wdata_q;
        col_ext      = 8'(col_q);
`ifdef START_LINE_EN
        start_line_d = start_line_q;
`endif
        if (bus.frame_abort) begin
            state_d = IDLE;
            skip_d  = 3'd0;
        end else if (bus.rx_valid && bus.rx_dc) begin
            // Data aborts any half-parsed command; address uses pre-increment pointer.
            state_d    = IDLE;
            skip_d     = 3'd0;
            fb_we_d    = 1'b1;
            fb_addr_d  = ADDR_W'({page_q, col_q});
            fb_wdata_d = rx;
            col_d      = col_nxt;
            page_d     = page_nxt;
        end else if (bus.rx_valid) begin
            case (state_q)
                IDLE: begin
                    if (rx == CMD_SET_MODE) begin
                        state_d = ARG1;
                        pend_d  = P_MODE;
                    end else if (rx == CMD_COL_ADDR) begin
                        state_d = ARG1;
                        pend_d  = P_COL;
                    end else if (rx == CMD_PAGE_ADDR) begin
                        state_d = ARG1;
                        pend_d  = P_PAGE;
                    end else if (rx[7:4] == 4'h0) begin
                        col_ext[3:0] = rx[3:0];
                        col_d        = col_ext[COL_W-1:0];
                    end else if (rx[7:4] == 4'h1) begin
                        col_ext[6:4] = rx[2:0];
                        col_d        = col_ext[COL_W-1:0];
                    end else if (rx[7:3] == 5'b10110) begin
                        page_d = rx[PAGE_W-1:0];
                    end else if (rx == CMD_DISP_ON || rx == CMD_DISP_OFF) begin
                        disp_d = rx[0];
                    end else if (rx == CMD_INVERT || rx == CMD_NORMAL) begin
                        inv_d = rx[0];
                    end else if (is_one_arg(rx)) begin
                        state_d = SKIP;
                        skip_d  = 3'd1;
                    end else if (rx == CMD_VSCROLL_AREA) begin
                        state_d = SKIP;
                        skip_d  = 3'd2;
                    end else if (rx == CMD_VSCROLL_R || rx == CMD_VSCROLL_L) begin
                        state_d = SKIP;
                        skip_d  = 3'd5;
                    end else if (rx == CMD_SCROLL_R || rx == CMD_SCROLL_L) begin
                        state_d = SKIP;
                        skip_d  = 3'd6;
                    end
`ifdef START_LINE_EN
                    else if (rx[7:6] == 2'b01) begin
                        start_line_d = rx[5:0];
                    end
`endif
                end
                ARG1: begin
                    if (pend_q == P_MODE) begin
                        if (rx[1:0] != 2'b11) mode_d = addr_mode_t'(rx[1:0]);
                        state_d = IDLE;
                    end else if (pend_q == P_COL) begin
                        col_start_d = rx[COL_W-1:0];
                        state_d     = ARG2;
                    end else begin
                        page_start_d = rx[PAGE_W-1:0];
                        state_d      = ARG2;
                    end
                end
                ARG2: begin
                    if (pend_q == P_COL) begin
                        col_end_d = rx[COL_W-1:0];
                        col_d     = col_start_q;
                    end else if (pend_q == P_PAGE) begin
                        page_end_d = rx[PAGE_W-1:0];
                        page_d     = page_start_q;
                    end
                    state_d = IDLE;
                end
                default: begin
                    if (skip_q <= 3'd1) begin
                        state_d = IDLE;
                        skip_d  = 3'd0;
                    end else begin
                        skip_d = skip_q - 3'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge greset) begin
        if (greset) begin
            state_q      <= IDLE;
            pend_q       <= P_MODE;
            skip_q       <= 3'd0;
            mode_q       <= PAGE;
            col_q        <= '0;
            page_q       <= '0;
            col_start_q  <= '0;
            col_end_q    <= COL_W'(COLS - 1);
            page_start_q <= '0;
            page_end_q   <= PAGE_W'(PAGES - 1);
            disp_q       <= 1'b0;
            inv_q        <= 1'b0;
            fb_we_q      <= 1'b0;
            fb_addr_q    <= '0;
            fb_wdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            skip_q       <= skip_d;
            mode_q       <= mode_d;
            col_q        <= col_d;
            page_q       <= page_d;
            col_start_q  <= col_start_d;
            col_end_q    <= col_end_d;
            page_start_q <= page_start_d;
            page_end_q   <= page_end_d;
            disp_q       <= disp_d;
            inv_q        <= inv_d;
            fb_we_q      <= fb_we_d;
            fb_addr_q    <= fb_addr_d;
            fb_wdata_q   <= fb_wdata_d;
        end
    end

`ifdef START_LINE_EN
    always_ff @(posedge clk or posedge greset) begin
        if (greset) start_line_q <= 6'd0;
        else        start_line_q <= start_line_d;
    end
    assign start_line = start_line_q;
`else
    assign start_line = 6'd0;
`endif

    assign bus.fb_we    = fb_we_q;
    assign bus.fb_addr  = fb_addr_q;
    assign bus.fb_wdata = fb_wdata_q;
    assign display_on   = disp_q;
    assign invert       = inv_q;
endmodule

// File: doc/ssd1306_cmd_ctrl.md
Name: ssd1306_cmd_ctrl

Overview:
- Command/data controller for the SSD1306-emulation framebuffer path. It sits between the SPI byte deserialiser, which is already in the clk domain, and the framebuffer write port.
- Parses the SSD1306 command stream: addressing mode, column/page windows, display on/off, invert.
- Turns data bytes into byte-wide framebuffer writes with SSD1306-accurate address auto-increment.
- Exports display_on and invert to the VGA scan-out.

Parameters:
COLS, 128, columns per page; power of two
PAGES, 8, pages of 8 rows each; power of two
ADDR_W, 10, framebuffer byte address width = log2(COLS*PAGES)

Ports:
clk  in  1  system clock (25 MHz pixel-domain clock)
greset  in  1  asynchronous active-high reset
frame_abort  in  1  pulse on CS deassert; drops any partially received command
rx_valid  in  1  one-cycle strobe, rx_data/rx_dc valid
rx_dc  in  1  1 = data byte, 0 = command byte
rx_data  in  8  received byte
fb_we  out  1  framebuffer byte write strobe
fb_addr  out  ADDR_W  write address = page*COLS + col
fb_wdata  out  8  write data (bit0 = top row of the page)
display_on  out  1  0xAF sets, 0xAE clears
invert  out  1  0xA7 sets, 0xA6 clears
start_line  out  6  display start line (see Optional Feature)

Behaviour:
- Reset values (async, greset=1):
  - all outputs 0
  - mode=PAGE(2), col=0, page=0
  - col_start=0, col_end=COLS-1, page_start=0, page_end=PAGES-1
  - parser in IDLE, skip_cnt=0
- Parser FSM states: IDLE, ARG1, ARG2, SKIP.
  - IDLE, command byte:
    - 0x20 -> ARG1 (pend=MODE)
    - 0x21 -> ARG1 (pend=COL)
    - 0x22 -> ARG1 (pend=PAGE)
    - 0x00-0x0F: col[3:0]=rx_data[3:0]
    - 0x10-0x1F: col[6:4]=rx_data[2:0]
    - 0xB0-0xB7: page=rx_data[2:0]
    - 0xAE/0xAF, 0xA6/0xA7: set the flag, next cycle
    - 1-arg opcodes {0x81,0x8D,0xA8,0xD3,0xD5,0xD9,0xDA,0xDB} -> SKIP with skip_cnt=1
    - 0xA3 -> SKIP, skip_cnt=2
    - 0x29/0x2A -> SKIP, skip_cnt=5
    - 0x26/0x27 -> SKIP, skip_cnt=6
    - all other opcodes: ignored, stay IDLE
  - ARG1:
    - MODE: if rx_data[1:0]!=3 then mode=rx_data[1:0]; value 3 leaves mode unchanged. -> IDLE
    - COL: col_start=rx_data[6:0]. -> ARG2
    - PAGE: page_start=rx_data[2:0]. -> ARG2
  - ARG2:
    - COL: col_end=rx_data[6:0], col=col_start.
    - PAGE: page_end=rx_data[2:0], page=page_start.
    - -> IDLE
  - SKIP: each command byte decrements skip_cnt; at 1 -> IDLE.
- Data byte (rx_dc=1), in any state:
  - Parser returns to IDLE; a pending command is discarded.
  - Write issued.
- Write latency: fb_we high exactly the cycle after the rx_valid cycle, for 1 cycle. fb_addr/fb_wdata are registered alongside it. fb_addr uses the pointer values before the increment.
- Pointer advance after each data byte:
  - HORIZONTAL(0): if col==col_end {col=col_start; page = (page==page_end)? page_start : page+1} else col+1.
  - VERTICAL(1): if page==page_end {page=page_start; col = (col==col_end)? col_start : col+1} else page+1.
  - PAGE(2): col = (col==COLS-1)? 0 : col+1; page unchanged.
- Inverted windows (start>end) are not special-cased. The pointer counts up, wraps naturally at COLS-1 / PAGES-1 to 0, and stops wrapping to start only on equality with end. Arithmetic is modulo COLS / PAGES.
- frame_abort: parser -> IDLE, skip_cnt=0; pointers and config registers are retained. If it coincides with rx_valid, abort wins and the byte is dropped.
- rx_valid while greset=1: ignored.

Optional Feature:
- Macro START_LINE_EN.
- Defined: command 0x40-0x7F sets start_line=rx_data[5:0] (next cycle); reset value 0.
- Undefined: 0x40-0x7F ignored as unknown commands; start_line tied to 0.

Decomposition:
- Package ssd1306_pkg:
  - addr_mode_t enum {HORIZ=0, VERT=1, PAGE=2}
  - parser_state_t enum {IDLE, ARG1, ARG2, SKIP}
  - pend_t enum {MODE, COL, PAGE}
  - opcode localparams (CMD_SET_MODE=0x20, CMD_COL_ADDR=0x21, CMD_PAGE_ADDR=0x22, CMD_DISP_OFF=0xAE, ...)
- Sub-module ssd1306_addr_gen: purely combinational next-pointer logic (mode, col, page, windows -> next col/page). Instantiated once.

Test Plan:
- Reset, then data bytes 0xAA,0x55 -> fb_we pulses at addr 0 and 1 with data 0xAA,0x55; display_on=0.
- Cmds 0x20,0x00, 0x21,0x7E,0x7F, 0x22,0x06,0x07, then 5 data bytes -> addrs 894, 895, 1022, 1023, 894.
- Cmds 0x20,0x01, 0x21,0x00,0x01, 0x22,0x00,0x01, 5 data -> addrs 0, 128, 1, 129, 0.
- Page mode: cmds 0xB3, 0x0F, 0x17, then 2 data bytes -> addrs 511, 384 (column wraps to 0, page 3 held).
- Cmds 0x81, 0xAF (0xAF consumed as contrast arg), then 0xAF -> display_on=1 only after the second 0xAF. Cmd 0x21 then frame_abort, then data -> write at unchanged col.
- START_LINE_EN on: cmd 0x55 -> start_line=0x15. Off: start_line stays 0 and the next 0x20,0x00 still parses correctly.
